trace_reader: RTL

- Consumer side of the datapath debug-observation interface: samples per-instruction debug values (PC, instruction, ALU result, control bits) exposed by the core top level.
- Buffers samples as 4-word records in a small FIFO.
- Drains records over a 32-bit valid/ready word stream to a host/UART/JTAG bridge.
- Sits beside the core top level; purely observational, never back-pressures the core.

---
 rtl/trace_reader_if.sv | 11 +
 rtl/trace_reader.sv | 111 +++++++++++
 2 files changed

// File: rtl/trace_reader_if.sv
// Word stream from trace_reader to a host/UART/JTAG bridge: 32-bit data,
// valid/ready handshake, and a last flag on the final word of each record.
interface trace_reader_if;
  logic [31:0] oData;
  logic        oValid;
  logic        iReady;
  logic        oLast;

  modport master (output oData, output oValid, output oLast, input iReady);
  modport slave  (input oData, input oValid, input oLast, output iReady);
endinterface

// File: rtl/trace_reader.sv
// Debug trace consumer: captures per-instruction core state into a record FIFO
// and streams each record as 4 words. Optional macro TRACE_WRITEBACK_FILTER_EN.
module trace_reader #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     iCapture,
  input  logic [31:0]              iPC,
  input  logic [31:0]              iInstruction,
  input  logic [31:0]              iAluResult,
  input  logic [4:0]               iRd,
  input  logic                     iRegWrite,
  input  logic                     iMemWrite,
  input  logic                     iMemRead,
  input  logic [1:0]               iOrigPC,
  input  logic [1:0]               iOrigWriteData,
  trace_reader_if.master           strm,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic                     oOverflow,
  output logic [CNT_W-1:0]         oDropCount
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wptr, rptr;
  logic [1:0]    idx;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic [31:0]   alu_mem [DEPTH];
  logic [11:0]   ctl_mem [DEPTH];

  logic          cap_req, full, accept, drop, hs, pop;
  logic [AW-1:0] ri;

`ifdef TRACE_WRITEBACK_FILTER_EN
  // Only instructions with an architectural side effect are worth tracing.
  assign cap_req = iCapture & (iRegWrite | iMemWrite);
`else
  assign cap_req = iCapture;
`endif

  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign accept = cap_req & ~full;
  assign drop   = cap_req & full;
  assign hs     = (state_q == SEND) & strm.iReady;
  assign pop    = hs & (idx == 2'd3);
  assign ri     = rptr[AW-1:0];
  assign oLevel = wptr - rptr;

  always_ff @(posedge clock) begin
    if (accept) begin
      pc_mem[wptr[AW-1:0]]  <= iPC;
      ins_mem[wptr[AW-1:0]] <= iInstruction;
      alu_mem[wptr[AW-1:0]] <= iAluResult;
      ctl_mem[wptr[AW-1:0]] <= {iOrigWriteData, iOrigPC, iMemRead, iMemWrite, iRegWrite, iRd};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      idx        <= '0;
      oOverflow  <= 1'b0;
      oDropCount <= '0;
    end else begin
      if (accept) wptr <= wptr + (AW+1)'(1);
      if (pop)    rptr <= rptr + (AW+1)'(1);
      if (hs)     idx  <= idx + 2'd1;
      if (drop) begin
        oOverflow <= 1'b1;
        if (oDropCount != {CNT_W{1'b1}}) oDropCount <= oDropCount + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state looks at this edge's capture so a fresh record is valid one
  // edge after capture and consecutive records stream without a bubble.
  always_comb begin
    state_d     = state_q;
    strm.oValid = 1'b0;
    strm.oLast  = 1'b0;
    strm.oData  = '0;
    case (state_q)
      IDLE: begin
        if (oLevel != '0 || accept) state_d = SEND;
      end
      SEND: begin
        strm.oValid = 1'b1;
        strm.oLast  = (idx == 2'd3);
        case (idx)
          2'd0: strm.oData = pc_mem[ri];
          2'd1: strm.oData = ins_mem[ri];
          2'd2: strm.oData = alu_mem[ri];
          default: strm.oData = {20'b0, ctl_mem[ri]};
        endcase
        if (pop && oLevel == (AW+1)'(1) && !accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
